// File: rtl/wbck_arbiter_if.sv
// Write-back bundle between the ALU/commit stage, long-pipe units and the register file.
// master = requester/RF side, slave = the arbiter.
interface wbck_arbiter_if #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
);
   logic                   alu_wbck_i_valid;
   logic                   alu_wbck_i_ready;
   logic [XLEN-1:0]        alu_wbck_i_wdat;
   logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;
   logic                   cmt_wbck_irqexcp;
   logic                   lp_wbck_i_valid;
   logic                   lp_wbck_i_ready;
   logic [XLEN-1:0]        lp_wbck_i_wdat;
   logic [RFIDX_WIDTH-1:0] lp_wbck_i_rdidx;
   logic                   wbck_o_rf_ena;
   logic [XLEN-1:0]        wbck_o_rf_wdat;
   logic [RFIDX_WIDTH-1:0] wbck_o_rf_rdidx;
   logic                   lp_pend;

   modport master (
      output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, cmt_wbck_irqexcp,
      output lp_wbck_i_valid, lp_wbck_i_wdat, lp_wbck_i_rdidx,
      input  alu_wbck_i_ready, lp_wbck_i_ready,
      input  wbck_o_rf_ena, wbck_o_rf_wdat, wbck_o_rf_rdidx, lp_pend
   );

   modport slave (
      input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, cmt_wbck_irqexcp,
      input  lp_wbck_i_valid, lp_wbck_i_wdat, lp_wbck_i_rdidx,
      output alu_wbck_i_ready, lp_wbck_i_ready,
      output wbck_o_rf_ena, wbck_o_rf_wdat, wbck_o_rf_rdidx, lp_pend
   );
endinterface

// File: rtl/wbck_arbiter.sv
// Register-file write-port arbiter: ALU wins by default, long-pipe FIFO head forced after STARVE_MAX losses.
// Latency: ALU 1 cycle, long-pipe >=2 cycles; long-pipe stalls only when its FIFO is full, ALU only on a forced FIFO grant.
module wbck_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         head_vld,
   output logic [W-1:0] head_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   // Full is judged on registered count, so a same-cycle pop never frees a slot.
   assign push_rdy = (count != CW'(DEPTH));
   assign head_vld = (count != '0);
   assign head_dat = mem[rd_ptr];
   assign do_push  = push_vld & push_rdy;
   assign do_pop   = pop & head_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module wbck_arbiter #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int LP_DEPTH    = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic           clk,
   input  logic           rst,
   wbck_arbiter_if.slave  wb
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef struct packed {
      logic [RFIDX_WIDTH-1:0] rdidx;
      logic [XLEN-1:0]        wdat;
   } wbck_ent_t;

   wbck_ent_t              lp_in;
   wbck_ent_t              head;
   logic                   head_vld;
   logic                   lp_rdy;
   logic                   force_lp;
   logic                   alu_grant;
   logic                   lp_grant;
   logic [SW-1:0]          starve_cnt;
   logic                   nxt_ena;
   logic [XLEN-1:0]        nxt_wdat;
   logic [RFIDX_WIDTH-1:0] nxt_rdidx;
   logic                   rf_ena;
   logic [XLEN-1:0]        rf_wdat;
   logic [RFIDX_WIDTH-1:0] rf_rdidx;

   assign lp_in.rdidx = wb.lp_wbck_i_rdidx;
   assign lp_in.wdat  = wb.lp_wbck_i_wdat;

   wbck_fifo #(
      .W     ($bits(wbck_ent_t)),
      .DEPTH (LP_DEPTH)
   ) u_lp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (wb.lp_wbck_i_valid),
      .push_rdy (lp_rdy),
      .push_dat (lp_in),
      .pop      (lp_grant),
      .head_vld (head_vld),
      .head_dat (head)
   );

   // Any cycle the ALU does not win, a waiting FIFO head takes the port.
   always_comb begin
      force_lp  = head_vld & (starve_cnt == STARVE_LIM);
      alu_grant = ~force_lp & wb.alu_wbck_i_valid;
      lp_grant  = head_vld & ~alu_grant;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!head_vld || lp_grant) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Writes to x0 and trapped ALU results still complete their handshake but never reach the RF.
   always_comb begin
      nxt_ena   = 1'b0;
      nxt_wdat  = '0;
      nxt_rdidx = '0;
      if (alu_grant) begin
         if (!wb.cmt_wbck_irqexcp && (wb.alu_wbck_i_rdidx != '0)) begin
            nxt_ena   = 1'b1;
            nxt_wdat  = wb.alu_wbck_i_wdat;
            nxt_rdidx = wb.alu_wbck_i_rdidx;
         end
      end else if (lp_grant) begin
         if (head.rdidx != '0) begin
            nxt_ena   = 1'b1;
            nxt_wdat  = head.wdat;
            nxt_rdidx = head.rdidx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_ena   <= 1'b0;
         rf_wdat  <= '0;
         rf_rdidx <= '0;
      end else begin
         rf_ena   <= nxt_ena;
         rf_wdat  <= nxt_wdat;
         rf_rdidx <= nxt_rdidx;
      end
   end

   assign wb.alu_wbck_i_ready = ~force_lp;
   assign wb.lp_wbck_i_ready  = lp_rdy;
   assign wb.wbck_o_rf_ena    = rf_ena;
   assign wb.wbck_o_rf_wdat   = rf_wdat;
   assign wb.wbck_o_rf_rdidx  = rf_rdidx;
   assign wb.lp_pend          = head_vld;

   a_no_double_grant: assert property (@(posedge clk) disable iff (rst) !(alu_grant && lp_grant));
   a_starve_bounded:  assert property (@(posedge clk) disable iff (rst) starve_cnt <= STARVE_LIM);
endmodule
